// File: rtl/edge_event_scheduler_pkg.sv
// Shared types and constants for the edge event scheduler.
package edge_sched_pkg;

   localparam int NUM_CH_DEFAULT = 4;
   localparam int CH_W = $clog2(NUM_CH_DEFAULT);

   localparam logic EVT_RISE = 1'b1;
   localparam logic EVT_FALL = 1'b0;

   typedef struct packed {
      logic [CH_W-1:0] ch;
      logic            rising;
   } evt_t;

endpackage

// File: rtl/edge_event_scheduler_if.sv
// Input lines, event port and overflow status of the edge event scheduler.
//
// Event port handshake: an event transfers on a posedge where evt_valid_o and
// evt_ready_i are both high; while valid is high and ready low, evt_ch_o and
// evt_rising_o stay stable and valid stays high.
interface edge_event_scheduler_if #(
   parameter int NUM_CH = 4
);
   localparam int CH_W = $clog2(NUM_CH);

   logic [NUM_CH-1:0] a_i;
   logic [NUM_CH-1:0] rise_en_i;
   logic [NUM_CH-1:0] fall_en_i;
   logic              evt_ready_i;
   logic              evt_valid_o;
   logic [CH_W-1:0]   evt_ch_o;
   logic              evt_rising_o;
   logic [NUM_CH-1:0] ovf_clr_i;
   logic [NUM_CH-1:0] ovf_o;
   logic [NUM_CH-1:0] pending_o;

   modport master (
      output a_i, rise_en_i, fall_en_i, evt_ready_i, ovf_clr_i,
      input  evt_valid_o, evt_ch_o, evt_rising_o, ovf_o, pending_o
   );

   modport slave (
      input  a_i, rise_en_i, fall_en_i, evt_ready_i, ovf_clr_i,
      output evt_valid_o, evt_ch_o, evt_rising_o, ovf_o, pending_o
   );

endinterface

// File: rtl/edge_event_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr, wrapping.
module rr_arbiter #(
   parameter int N = 4,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   input  logic         en,
   output logic [W-1:0] gnt_idx,
   output logic         gnt_valid
);

   int idx;

   // Scan from farthest to nearest so the nearest request is the last write.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      idx       = 0;
      for (int i = N - 1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % N;
         if (en && req[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = idx[W-1:0];
         end
      end
   end

endmodule

// File: rtl/edge_event_scheduler.sv
// Per-channel edge detect with a one-deep pending slot, round-robin onto a
// single registered valid/ready event port.
module edge_event_scheduler
   import edge_sched_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEFAULT
) (
   input logic                   clk,
   input logic                   reset,
   edge_event_scheduler_if.slave bus
);

   localparam int CHW = $clog2(NUM_CH);

   logic [NUM_CH-1:0] pend;
   logic [NUM_CH-1:0] typ;
   logic [NUM_CH-1:0] ovf;
   logic [CHW-1:0]    ptr;
   logic              out_valid;
   logic [CHW-1:0]    out_ch;
   logic              out_rising;
   logic              out_free;
   logic [CHW-1:0]    gnt_idx;
   logic              gnt_valid;

   assign out_free = ~out_valid | bus.evt_ready_i;

   rr_arbiter #(.N(NUM_CH)) u_arb (
      .req       (pend),
      .ptr       (ptr),
      .en        (out_free),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      localparam logic [CHW-1:0] G_IDX = CHW'(g);

      logic a_ff;
      logic pend_q;
      logic typ_q;
      logic ovf_q;
      logic rise;
      logic fall;
      logic granted;
      logic drop;

      assign rise    = ~a_ff & bus.a_i[g] & bus.rise_en_i[g];
      assign fall    = a_ff & ~bus.a_i[g] & bus.fall_en_i[g];
      assign granted = gnt_valid && (gnt_idx == G_IDX);
      // A slot being granted this cycle counts as empty for a new edge.
      assign drop    = (rise | fall) & pend_q & ~granted;

      always_ff @(posedge clk) begin
         if (reset) begin
            a_ff   <= 1'b0;
            pend_q <= 1'b0;
            typ_q  <= EVT_FALL;
            ovf_q  <= 1'b0;
         end else begin
            a_ff <= bus.a_i[g];
            if ((rise | fall) && !drop) begin
               pend_q <= 1'b1;
               typ_q  <= rise ? EVT_RISE : EVT_FALL;
            end else if (granted) begin
               pend_q <= 1'b0;
            end
            if (drop) begin
               ovf_q <= 1'b1;
            end else if (bus.ovf_clr_i[g]) begin
               ovf_q <= 1'b0;
            end
         end
      end

      assign pend[g] = pend_q;
      assign typ[g]  = typ_q;
      assign ovf[g]  = ovf_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr        <= '0;
         out_valid  <= 1'b0;
         out_ch     <= '0;
         out_rising <= 1'b0;
      end else if (out_free) begin
         if (gnt_valid) begin
            out_valid  <= 1'b1;
            out_ch     <= gnt_idx;
            out_rising <= typ[gnt_idx];
            ptr        <= (gnt_idx == CHW'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

   assign bus.evt_valid_o  = out_valid;
   assign bus.evt_ch_o     = out_ch;
   assign bus.evt_rising_o = out_rising;
   assign bus.ovf_o        = ovf;
   assign bus.pending_o    = pend;

endmodule

// File: doc/edge_event_scheduler.md
# edge_event_scheduler

Collects rising/falling edge events from NUM_CH single-bit input lines and delivers them one at a time on a shared valid/ready event port. Each channel holds one pending event; a round-robin arbiter shares the output between channels. It sits between the synchronized input lines and the firmware-facing event consumer (interrupt/event FIFO). Dropped events are flagged per channel.

## Interface
- NUM_CH, 4: number of input channels, 2..16.
- CH_W, $clog2(NUM_CH): channel index width (derived, not overridden).
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- a_i  in  NUM_CH  input lines, already synchronized to clk.
- rise_en_i  in  NUM_CH  per-channel enable for rising-edge events.
- fall_en_i  in  NUM_CH  per-channel enable for falling-edge events.
- evt_ready_i  in  1  consumer accepts the event when high with evt_valid_o.
- evt_valid_o  out  1  event present on the output register.
- evt_ch_o  out  CH_W  channel index of the presented event.
- evt_rising_o  out  1  1 = rising edge, 0 = falling edge.
- ovf_clr_i  in  NUM_CH  per-channel clear of the overflow flags.
- ovf_o  out  NUM_CH  sticky per-channel overflow (event dropped).
- pending_o  out  NUM_CH  per-channel pending-slot occupancy.

## Operation
- Per channel: a_ff register tracks a_i every cycle, regardless of enables. rise = ~a_ff & a_i & rise_en_i; fall = a_ff & ~a_i & fall_en_i.
- Per channel one pending slot {pend, type}. A detected edge loads the slot if it is empty or is being granted in the same cycle; otherwise the new event is dropped, the slot is unchanged, and the ovf bit is set.
- The enables gate detection only. Events already pending are delivered even if the enable later drops.
- Output register {evt_valid_o, evt_ch_o, evt_rising_o} is free when ~evt_valid_o | evt_ready_i.
- When the output register is free and any pend is set, grant one channel:
  - the first pending channel at or after ptr, wrapping modulo NUM_CH;
  - copy its slot into the output register, clear its pend, and set ptr to grant+1 (NUM_CH-1 wraps to 0).
- With no grant, ptr holds. If the register is free and nothing is pending, evt_valid_o falls to 0.
- While evt_valid_o & ~evt_ready_i, all output fields are held stable. No event is lost or duplicated on the output.
- ovf: set has priority over ovf_clr_i in the same cycle; otherwise ovf_clr_i clears the bit.
- Reset values (all 0): a_ff, pend, type, ptr, evt_valid_o, evt_ch_o, evt_rising_o, ovf_o. pending_o = pend.
- Reset mid-operation discards pending and presented events with no acceptance.
- Because a_ff resets to 0, a line held high through reset yields a rising event (if enabled) one cycle after reset deasserts.

## Timing
- Edge seen in cycle N (a_i ≠ a_ff): pend visible in N+1, and evt_valid_o high in N+2 if the output is free. Minimum latency is 2 cycles.
- Throughput is one event per cycle while evt_ready_i is held high.
- Simultaneous edges on k channels are delivered in round-robin order over k consecutive accepting cycles.
- A second edge on a channel whose event is being granted in the same cycle is accepted without overflow.
- Worst-case wait for a pending channel is NUM_CH-1 grants.

## Structure
- Package edge_sched_pkg holds:
  - typedef evt_t {logic [CH_W-1:0] ch; logic rising;};
  - localparams EVT_RISE=1'b1 and EVT_FALL=1'b0;
  - a default NUM_CH constant.
- Sub-module rr_arbiter (parameter N; inputs req[N], ptr, en; outputs gnt_idx, gnt_valid) is purely combinational. The ptr register stays in edge_event_scheduler.
- Per-channel detect and slot logic live in a generate loop in the top module.

## Test plan
- Reset, a_i=0, all enables 1. Pulse a_i[2] high for 3 cycles with ready=1 -> rising event {ch=2} at N+2, falling event {ch=2} 3 cycles later, ovf_o=0.
- a_i[0], a_i[1], a_i[3] rise in the same cycle, ready=1, ptr=0 -> events ch 0,1,3 on consecutive cycles; ptr ends at 0.
- ready=0, toggle a_i[1] 0->1->0 on consecutive cycles -> first (rising) event held on the output. Slot 1 then holds the falling event, and a third edge sets ovf_o[1]. Assert ovf_clr_i[1] -> ovf_o[1]=0 next cycle.
- rise_en_i[0]=0 with a rising then falling edge on a_i[0] -> only the falling event is delivered; a_ff still updates.
- Hold a_i[3]=1 through reset, deassert reset -> rising {ch=3} event; assert reset mid-delivery -> evt_valid_o=0 and pending_o=0 next cycle.
